// File: rtl/cp_symbol_scheduler_if.sv
// Handshake and data bundle between the IFFT output stage, the symbol scheduler
// and the cyclic-prefix inserter.
interface cp_symbol_scheduler_if #(
  parameter int unsigned WIDTH = 20
);
  logic             frame_start;
  logic [7:0]       num_syms;
  logic             abort;
  logic             ifft_valid;
  logic [WIDTH-1:0] ifft_real;
  logic [WIDTH-1:0] ifft_imag;
  logic             ifft_ready;
  logic             din_valid;
  logic [5:0]       din_index;
  logic [WIDTH-1:0] cp_real_din;
  logic [WIDTH-1:0] cp_imag_din;
  logic             busy;
  logic [7:0]       sym_count;
  logic             frame_done;
  logic             underrun;

  modport master (
    output frame_start, num_syms, abort, ifft_valid, ifft_real, ifft_imag,
    input  ifft_ready, din_valid, din_index, cp_real_din, cp_imag_din,
    input  busy, sym_count, frame_done, underrun
  );

  modport slave (
    input  frame_start, num_syms, abort, ifft_valid, ifft_real, ifft_imag,
    output ifft_ready, din_valid, din_index, cp_real_din, cp_imag_din,
    output busy, sym_count, frame_done, underrun
  );
endinterface

// File: rtl/cp_symbol_scheduler.sv
// Paces IFFT samples into the CP inserter as fixed 64-sample bursts followed by
// N_CP idle cycles, zero-filling underruns and reporting frame completion.
module cp_symbol_scheduler #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned N_FFT = 64,
  parameter int unsigned N_CP  = 16
) (
  input logic                  cp_clk,
  input logic                  cp_rst,
  cp_symbol_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StLoad, StGap} state_e;

  localparam logic [6:0] LastIdx = 7'(N_FFT - 1);
  localparam logic [6:0] LastGap = 7'(N_CP - 1);

  state_e           r_state;
  logic [6:0]       r_cnt;
  logic [7:0]       r_num_syms;
  logic [7:0]       r_sym_count;
  logic             r_din_valid;
  logic [5:0]       r_din_index;
  logic [WIDTH-1:0] r_real;
  logic [WIDTH-1:0] r_imag;
  logic             r_busy;
  logic             r_frame_done;
  logic             r_underrun;

  always_ff @(posedge cp_clk or posedge cp_rst) begin
    if (cp_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_num_syms   <= '0;
      r_sym_count  <= '0;
      r_din_valid  <= 1'b0;
      r_din_index  <= '0;
      r_real       <= '0;
      r_imag       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (bus.abort && (r_state != StIdle)) begin
        // Drop the frame silently; sym_count keeps the progress made so far.
        r_state     <= StIdle;
        r_busy      <= 1'b0;
        r_cnt       <= '0;
        r_din_valid <= 1'b0;
        r_din_index <= '0;
        r_real      <= '0;
        r_imag      <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (bus.frame_start && (bus.num_syms != 8'd0) && !bus.abort) begin
              r_num_syms  <= bus.num_syms;
              r_sym_count <= '0;
              r_underrun  <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= StWait;
            end
          end
          StWait: begin
            r_din_index <= '0;
            if (bus.ifft_valid) begin
              r_din_valid <= 1'b1;
              r_real      <= bus.ifft_real;
              r_imag      <= bus.ifft_imag;
              r_cnt       <= 7'd1;
              r_state     <= StLoad;
            end else begin
              r_din_valid <= 1'b0;
              r_real      <= '0;
              r_imag      <= '0;
            end
          end
          StLoad: begin
            // The burst never stretches: a missing sample becomes a zero.
            r_din_valid <= 1'b1;
            r_din_index <= r_cnt[5:0];
            if (bus.ifft_valid) begin
              r_real <= bus.ifft_real;
              r_imag <= bus.ifft_imag;
            end else begin
              r_real     <= '0;
              r_imag     <= '0;
              r_underrun <= 1'b1;
            end
            if (r_cnt == LastIdx) begin
              r_cnt   <= '0;
              r_state <= StGap;
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
          StGap: begin
            r_din_valid <= 1'b0;
            r_din_index <= '0;
            r_real      <= '0;
            r_imag      <= '0;
            if (r_cnt == LastGap) begin
              r_cnt       <= '0;
              r_sym_count <= r_sym_count + 8'd1;
              if ((r_sym_count + 8'd1) == r_num_syms) begin
                r_frame_done <= 1'b1;
                r_busy       <= 1'b0;
                r_state      <= StIdle;
              end else begin
                r_state <= StWait;
              end
            end else begin
              r_cnt <= r_cnt + 7'd1;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.ifft_ready  = (r_state == StWait) || (r_state == StLoad);
  assign bus.din_valid   = r_din_valid;
  assign bus.din_index   = r_din_index;
  assign bus.cp_real_din = r_real;
  assign bus.cp_imag_din = r_imag;
  assign bus.busy        = r_busy;
  assign bus.sym_count   = r_sym_count;
  assign bus.frame_done  = r_frame_done;
  assign bus.underrun    = r_underrun;

endmodule
